// File: rtl/io_input_debounce.sv
// io_input_debounce: 2-FF sync + per-bit stability debounce for sw/dip pins.
// Ports: sys_clk_in, reset (sync, active-high), sw_pin/dip_pin (raw, async),
//   clr_pending (clears chg_pending), sw_word/dip_word (zero-extended stable
//   bits), sw_edge/dip_edge (toggle pulses), chg_pending (sticky change flag),
//   change_cnt (toggle-cycle count, only when IO_DEBOUNCE_CHGCNT_EN is defined,
//   else tied to 0).
module io_input_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             sys_clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_pin,
  input  logic [WIDTH-1:0] dip_pin,
  input  logic             clr_pending,
  output logic [31:0]      sw_word,
  output logic [31:0]      dip_word,
  output logic [WIDTH-1:0] sw_edge,
  output logic [WIDTH-1:0] dip_edge,
  output logic             chg_pending,
  output logic [15:0]      change_cnt
);

  // Both groups share one datapath: low half is sw, high half is dip.
  localparam int N = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     pins;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     stable;
  logic [N-1:0]     hit;
  logic [N-1:0]     edge_q;
  logic [CNT_W-1:0] cnt   [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             chg_q;

  assign pins = {dip_pin, sw_pin};

  // hit: bit has disagreed with stable for DEBOUNCE_CYCLES cycles,
  // so it flips this edge. Any agreement restarts the count.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hit[i]   = 1'b0;
      cnt_d[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == LAST) begin
          hit[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      edge_q <= '0;
      chg_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1     <= pins;
      s2     <= s1;
      stable <= stable ^ hit;
      edge_q <= hit;
      // a toggle beats a simultaneous clear
      chg_q  <= (|hit) | (chg_q & ~clr_pending);
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_d[i];
      end
    end
  end

  assign sw_word     = 32'(stable[WIDTH-1:0]);
  assign dip_word    = 32'(stable[N-1:WIDTH]);
  assign sw_edge     = edge_q[WIDTH-1:0];
  assign dip_edge    = edge_q[N-1:WIDTH];
  assign chg_pending = chg_q;

`ifdef IO_DEBOUNCE_CHGCNT_EN
  logic [15:0] change_cnt_q;

  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      change_cnt_q <= '0;
    end else if ((|edge_q) && (change_cnt_q != 16'hFFFF)) begin
      change_cnt_q <= change_cnt_q + 16'd1;
    end
  end

  assign change_cnt = change_cnt_q;
`else
  assign change_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// tb_io_input_debounce: directed checks of io_input_debounce
// with WIDTH=5, DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_io_input_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sw_pin;
  logic [4:0]  dip_pin;
  logic        clr_pending;
  logic [31:0] sw_word;
  logic [31:0] dip_word;
  logic [4:0]  sw_edge;
  logic [4:0]  dip_edge;
  logic        chg_pending;
  logic [15:0] change_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  io_input_debounce #(
    .WIDTH(5),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .sys_clk_in (clk),
    .reset      (reset),
    .sw_pin     (sw_pin),
    .dip_pin    (dip_pin),
    .clr_pending(clr_pending),
    .sw_word    (sw_word),
    .dip_word   (dip_word),
    .sw_edge    (sw_edge),
    .dip_edge   (dip_edge),
    .chg_pending(chg_pending),
    .change_cnt (change_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic saw_dip_edge;

  initial begin
    reset = 1'b1;
    sw_pin = '0;
    dip_pin = '0;
    clr_pending = 1'b0;
    saw_dip_edge = 1'b0;

    // 1: reset state
    tick(3);
    chk("rst_sw_word", sw_word, 32'h0);
    chk("rst_dip_word", dip_word, 32'h0);
    chk("rst_sw_edge", 32'(sw_edge), 32'h0);
    chk("rst_dip_edge", 32'(dip_edge), 32'h0);
    chk("rst_chg", 32'(chg_pending), 32'h0);
    chk("rst_cnt", 32'(change_cnt), 32'h0);
    reset = 1'b0;
    tick(2);

    // 2: clean sw[0] rise, stable on the 6th edge
    sw_pin = 5'b00001;
    tick(5);
    chk("lat_sw_before", sw_word, 32'h0);
    tick(1);
    chk("lat_sw_word", sw_word, 32'h1);
    chk("lat_sw_edge", 32'(sw_edge), 32'h1);
    chk("lat_chg", 32'(chg_pending), 32'h1);
    tick(1);
    chk("lat_edge_gone", 32'(sw_edge), 32'h0);
    chk("lat_sw_hold", sw_word, 32'h1);
    clr_pending = 1'b1;
    tick(1);
    clr_pending = 1'b0;
    chk("clr_chg", 32'(chg_pending), 32'h0);
    clr_pending = 1'b1;
    tick(1);
    clr_pending = 1'b0;
    chk("clr_idle", 32'(chg_pending), 32'h0);

    // 3: 3-cycle dip[2] glitch is rejected
    dip_pin = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (dip_edge != 5'b0) saw_dip_edge = 1'b1;
    end
    dip_pin = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (dip_edge != 5'b0) saw_dip_edge = 1'b1;
    end
    chk("glitch_dip_word", dip_word, 32'h0);
    chk("glitch_dip_edge", 32'(saw_dip_edge), 32'h0);
    chk("glitch_chg", 32'(chg_pending), 32'h0);

    // 4: clear during the toggle cycle loses to the set
    sw_pin = 5'b01001;
    tick(5);
    clr_pending = 1'b1;
    tick(1);
    clr_pending = 1'b0;
    chk("setwin_sw_word", sw_word, 32'h9);
    chk("setwin_sw_edge", 32'(sw_edge), 32'h8);
    chk("setwin_chg", 32'(chg_pending), 32'h1);
    clr_pending = 1'b1;
    tick(1);
    clr_pending = 1'b0;
    chk("lone_clr_chg", 32'(chg_pending), 32'h0);

    // 5: reset mid-debounce, then full latency from release
    sw_pin = 5'b11111;
    dip_pin = 5'b10101;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("midrst_sw_word", sw_word, 32'h0);
    chk("midrst_dip_word", dip_word, 32'h0);
    chk("midrst_chg", 32'(chg_pending), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("rel_sw_before", sw_word, 32'h0);
    chk("rel_dip_before", dip_word, 32'h0);
    tick(1);
    chk("rel_sw_word", sw_word, 32'h1F);
    chk("rel_dip_word", dip_word, 32'h15);
    chk("rel_sw_edge", 32'(sw_edge), 32'h1F);
    chk("rel_dip_edge", 32'(dip_edge), 32'h15);
    chk("rel_chg", 32'(chg_pending), 32'h1);
    tick(2);

`ifdef IO_DEBOUNCE_CHGCNT_EN
    // 6: toggle counter, counting and saturation
    chk("cnt_after_rel", 32'(change_cnt), 32'h1);
    reset = 1'b1;
    sw_pin = '0;
    dip_pin = '0;
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw_pin = sw_pin ^ 5'b00001;
      tick(9);
    end
    chk("cnt_three", 32'(change_cnt), 32'h3);
    force dut.change_cnt_q = 16'hFFFE;
    #1;
    release dut.change_cnt_q;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      sw_pin = sw_pin ^ 5'b00010;
      tick(9);
    end
    chk("cnt_sat", 32'(change_cnt), 32'hFFFF);
`else
    chk("cnt_tied", 32'(change_cnt), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
